// File: rtl/pdm_capture_ctrl_if.sv
// Control/status bundle between the register block, the CIC3 decimator and the PDM capture sequencer.
interface pdm_capture_ctrl_if #(
  parameter int unsigned PCM_W = 16
);
  logic             start;
  logic             stop;
  logic [7:0]       clk_div;
  logic [7:0]       settle_cnt;
  logic [3:0]       threshold;
  logic [PCM_W-1:0] pcm_in;
  logic             pcm_valid;
  logic             overrun_clr;
  logic             pop;

  logic             pdm_clk_out;
  logic             filter_rst;
  logic [PCM_W-1:0] rd_data;
  logic [3:0]       level;
  logic             empty;
  logic             overrun;
  logic             irq;
  logic [1:0]       state;

  modport master (
    output start, stop, clk_div, settle_cnt, threshold, pcm_in, pcm_valid, overrun_clr, pop,
    input  pdm_clk_out, filter_rst, rd_data, level, empty, overrun, irq, state
  );

  modport slave (
    input  start, stop, clk_div, settle_cnt, threshold, pcm_in, pcm_valid, overrun_clr, pop,
    output pdm_clk_out, filter_rst, rd_data, level, empty, overrun, irq, state
  );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: gated PDM bit clock, decimator reset, settle-sample discard,
// PCM sample FIFO with threshold/overrun interrupt.
module pdm_capture_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCM_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pdm_capture_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CMP_W = (LVL_W > 4) ? LVL_W : 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   disc_q, disc_inc_c;
  logic [CNT_W-1:0]   phase_q, per_q, per_sel_c;
  logic               pdm_q, filt_q, filt_nx;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_nx;
  logic               ovr_q, ovr_nx, irq_q, irq_nx;
  logic [PCM_W-1:0]   mem [DEPTH];

  logic flush_c, discard_c, push_req_c, run_c;
  logic empty_c, full_c, pop_ok_c, push_ok_c, ovr_set_c;

  assign disc_inc_c = CNT_W'(disc_q + CNT_W'(1));
  assign per_sel_c  = (bus.clk_div < CNT_W'(2)) ? CNT_W'(2) : bus.clk_div;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state logic; stop always wins over start
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop)
          state_nx = (bus.settle_cnt != '0) ? ST_WARMUP : ST_RUN;
      end
      ST_WARMUP: begin
        if (bus.stop)
          state_nx = ST_IDLE;
        else if (bus.pcm_valid && (disc_inc_c == bus.settle_cnt))
          state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    flush_c    = 1'b0;
    discard_c  = 1'b0;
    push_req_c = 1'b0;
    run_c      = (state_q != ST_IDLE) && (state_nx != ST_IDLE);
    filt_nx    = (state_nx == ST_IDLE);
    case (state_q)
      ST_IDLE:   flush_c    = bus.start && !bus.stop;
      ST_WARMUP: discard_c  = bus.pcm_valid;
      ST_RUN:    push_req_c = bus.pcm_valid;
      default:   ;
    endcase
  end

  // PDM clock: period reloads only at wrap so a clk_div write never glitches a cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      per_q   <= '0;
      pdm_q   <= 1'b0;
    end else if (run_c) begin
      pdm_q <= (phase_q < (per_q >> 1));
      if (phase_q == CNT_W'(per_q - CNT_W'(1))) begin
        phase_q <= '0;
        per_q   <= per_sel_c;
      end else begin
        phase_q <= CNT_W'(phase_q + CNT_W'(1));
      end
    end else begin
      phase_q <= '0;
      per_q   <= per_sel_c;
      pdm_q   <= 1'b0;
    end
  end

  assign empty_c   = (level_q == '0);
  assign full_c    = (level_q == LVL_W'(DEPTH));
  assign pop_ok_c  = bus.pop && !empty_c && !flush_c;
  assign push_ok_c = push_req_c && (!full_c || pop_ok_c);
  assign ovr_set_c = push_req_c && full_c && !pop_ok_c;

  always_comb begin
    level_nx = flush_c ? '0
             : LVL_W'(level_q + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c));
    if (flush_c)          ovr_nx = 1'b0;
    else if (ovr_set_c)   ovr_nx = 1'b1;
    else if (bus.overrun_clr) ovr_nx = 1'b0;
    else                  ovr_nx = ovr_q;
    irq_nx = ovr_nx || ((bus.threshold != '0) &&
                        (CMP_W'(level_nx) >= CMP_W'(bus.threshold)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      filt_q   <= 1'b1;
      disc_q   <= '0;
    end else begin
      level_q <= level_nx;
      ovr_q   <= ovr_nx;
      irq_q   <= irq_nx;
      filt_q  <= filt_nx;
      if (flush_c) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        disc_q   <= '0;
      end else begin
        if (push_ok_c) wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
        if (pop_ok_c)  rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
        if (discard_c) disc_q   <= disc_inc_c;
      end
    end
  end

  // Sample storage needs no reset: rd_data is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= bus.pcm_in;
  end

  assign bus.pdm_clk_out = pdm_q;
  assign bus.filter_rst  = filt_q;
  assign bus.rd_data     = empty_c ? '0 : mem[rd_ptr_q];
  assign bus.level       = 4'(level_q);
  assign bus.empty       = empty_c;
  assign bus.overrun     = ovr_q;
  assign bus.irq         = irq_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Bench for pdm_capture_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_pdm_capture_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PCM_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pdm_capture_ctrl_if #(.PCM_W(PCM_W)) bus ();
  pdm_capture_ctrl #(.DEPTH(DEPTH), .PCM_W(PCM_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [PCM_W-1:0] q[$];
  int m_mode, m_disc, m_ph, m_per;
  bit m_ovr, m_pdm, m_filt, m_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per_of(input logic [7:0] d);
    return (d < 8'd2) ? 2 : int'(d);
  endfunction

  // One clock of spec behaviour, using the inputs seen at the edge
  task automatic model_step();
    int nxt;
    bit ev_ovr;
    if (!rst_n) begin
      q.delete(); m_mode = 0; m_disc = 0; m_ph = 0; m_per = 2;
      m_ovr = 0; m_pdm = 0; m_filt = 1; m_irq = 0;
      return;
    end
    if (m_mode == 0 && bus.start && !bus.stop) begin
      q.delete(); m_ovr = 0; m_disc = 0;
    end else begin
      ev_ovr = 0;
      if (bus.pop && q.size() != 0) void'(q.pop_front());
      if (bus.pcm_valid && m_mode == 2) begin
        if (q.size() < DEPTH) q.push_back(bus.pcm_in);
        else ev_ovr = 1;
      end
      if (ev_ovr) m_ovr = 1;
      else if (bus.overrun_clr) m_ovr = 0;
    end
    nxt = m_mode;
    if (bus.stop) nxt = 0;
    else if (m_mode == 0) begin
      if (bus.start) nxt = (bus.settle_cnt != 0) ? 1 : 2;
    end else if (m_mode == 1 && bus.pcm_valid) begin
      m_disc = (m_disc + 1) % 256;
      if (m_disc == int'(bus.settle_cnt)) nxt = 2;
    end
    if (m_mode != 0 && nxt != 0) begin
      m_pdm = (m_ph < m_per / 2);
      m_ph++;
      if (m_ph == m_per) begin m_ph = 0; m_per = per_of(bus.clk_div); end
    end else begin
      m_pdm = 0; m_ph = 0; m_per = per_of(bus.clk_div);
    end
    m_mode = nxt;
    m_filt = (nxt == 0);
    m_irq  = m_ovr || (bus.threshold != 0 && q.size() >= int'(bus.threshold));
  endtask

  task automatic check_all();
    chk("state",      32'(bus.state),       m_mode);
    chk("filter_rst", 32'(bus.filter_rst),  32'(m_filt));
    chk("pdm_clk",    32'(bus.pdm_clk_out), 32'(m_pdm));
    chk("level",      32'(bus.level),       q.size());
    chk("empty",      32'(bus.empty),       32'(q.size() == 0));
    chk("overrun",    32'(bus.overrun),     32'(m_ovr));
    chk("irq",        32'(bus.irq),         32'(m_irq));
    chk("rd_data",    32'(bus.rd_data),     (q.size() != 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    bus.start = 1'b0; bus.stop = 1'b0; bus.pcm_valid = 1'b0;
    bus.pop = 1'b0; bus.overrun_clr = 1'b0;
  endtask

  task automatic push(input logic [PCM_W-1:0] v);
    bus.pcm_in = v; bus.pcm_valid = 1'b1; tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clk_div = 8'd4; bus.settle_cnt = 8'd0;
    bus.threshold = 4'd0; bus.pcm_in = '0; bus.pcm_valid = 1'b0;
    bus.overrun_clr = 1'b0; bus.pop = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_filt",  32'(bus.filter_rst), 1);
    rst_n = 1'b1;
    tick();

    // start straight into RUN, clk_div = 4
    bus.start = 1'b1; tick();
    chk("run_state", 32'(bus.state), 2);
    chk("run_filt",  32'(bus.filter_rst), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pdm_div4", 32'(bus.pdm_clk_out), 32'((i % 4) < 2));
    end

    // three settle samples discarded
    bus.stop = 1'b1; tick();
    bus.settle_cnt = 8'd3; bus.start = 1'b1; tick();
    chk("warmup_state", 32'(bus.state), 1);
    for (int v = 1; v <= 5; v++) push(16'(v));
    chk("settle_level", 32'(bus.level), 2);
    chk("settle_head",  32'(bus.rd_data), 32'h4);
    bus.pop = 1'b1; tick();
    chk("settle_head2", 32'(bus.rd_data), 32'h5);
    bus.pop = 1'b1; tick();
    chk("settle_empty", 32'(bus.empty), 1);

    // threshold interrupt
    bus.threshold = 4'd4;
    for (int v = 0; v < 3; v++) push(16'(16'h40 + v));
    chk("thr_irq_lo", 32'(bus.irq), 0);
    bus.pcm_in = 16'h43; bus.pcm_valid = 1'b1; tick();
    chk("thr_irq_hi", 32'(bus.irq), 1);
    bus.pop = 1'b1; tick();
    chk("thr_irq_fall", 32'(bus.irq), 0);

    // overflow, push+pop while full, overrun clear
    bus.stop = 1'b1; tick();
    bus.settle_cnt = 8'd0; bus.start = 1'b1; tick();
    for (int v = 0; v < 9; v++) push(16'(16'h100 + v));
    chk("full_level", 32'(bus.level), 8);
    chk("full_ovr",   32'(bus.overrun), 1);
    chk("full_irq",   32'(bus.irq), 1);
    chk("full_head",  32'(bus.rd_data), 32'h100);
    bus.pcm_in = 16'h2AA; bus.pcm_valid = 1'b1; bus.pop = 1'b1; tick();
    chk("pp_level", 32'(bus.level), 8);
    chk("pp_head",  32'(bus.rd_data), 32'h101);
    for (int i = 0; i < 7; i++) begin bus.pop = 1'b1; tick(); end
    chk("pp_tail", 32'(bus.rd_data), 32'h2AA);
    bus.overrun_clr = 1'b1; tick();
    chk("ovr_clr", 32'(bus.overrun), 0);

    // stop keeps data, start+stop ignored, fresh start flushes
    push(16'h3001); push(16'h3002);
    bus.stop = 1'b1; tick();
    chk("stop_pdm",   32'(bus.pdm_clk_out), 0);
    chk("stop_filt",  32'(bus.filter_rst), 1);
    chk("stop_level", 32'(bus.level), 3);
    bus.pop = 1'b1; tick();
    chk("stop_read", 32'(bus.rd_data), 32'h3001);
    bus.start = 1'b1; bus.stop = 1'b1; tick();
    chk("ss_state", 32'(bus.state), 0);
    bus.start = 1'b1; tick();
    chk("restart_level", 32'(bus.level), 0);

    // minimum and maximum PDM periods
    for (int d = 0; d < 2; d++) begin
      bus.stop = 1'b1; tick();
      bus.clk_div = 8'(d); bus.start = 1'b1; tick();
      for (int i = 0; i < 6; i++) begin
        tick();
        chk("pdm_min", 32'(bus.pdm_clk_out), 32'((i % 2) == 0));
      end
    end
    bus.stop = 1'b1; tick();
    bus.clk_div = 8'd255; bus.start = 1'b1; tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("pdm_255", 32'(bus.pdm_clk_out), 32'((i % 255) < 127));
    end

    // reset in the middle of RUN
    push(16'h55AA);
    rst_n = 1'b0; tick();
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_level", 32'(bus.level), 0);
    chk("mid_rst_pdm",   32'(bus.pdm_clk_out), 0);
    rst_n = 1'b1; tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) bus.clk_div    = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 99) == 0) bus.settle_cnt = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) bus.threshold  = 4'($urandom_range(0, 15));
      bus.start       = ($urandom_range(0, 15) == 0);
      bus.stop        = ($urandom_range(0, 79) == 0);
      bus.pcm_valid   = ($urandom_range(0, 2) == 0);
      bus.pcm_in      = 16'($urandom);
      bus.pop         = ($urandom_range(0, 3) == 0);
      bus.overrun_clr = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
